mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are clk (rising edge) and rst_n.
REQ-002 clk  input  1  system clock; shared with the data memory.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  CPU access request; sampled only when ready=1.
REQ-005 we  input  1  1=store, 0=load.
REQ-006 size  input  2  access size: 00=byte, 01=half, 10=word, 11=reserved.
REQ-007 sign_ext  input  1  load result: 1=sign-extend, 0=zero-extend.
REQ-008 addr  input  32  CPU byte address.
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 ready  output  1  unit idle; a request is accepted on this cycle.
REQ-011 resp_valid  output  1  one-cycle pulse marking completion.
REQ-012 resp_err  output  1  misaligned or reserved-size request; qualified by resp_valid.
REQ-013 rdata  output  32  load result; qualified by resp_valid.
REQ-014 mem_a  output  32  data-memory byte address; always word-aligned.
REQ-015 mem_wd  output  32  data-memory write word.
REQ-016 mem_we  output  1  data-memory write enable, covering all 4 bytes.
REQ-017 mem_rd  input  32  data-memory read word; valid 1 cycle after mem_a is sampled.

Function
REQ-018 The data memory SHALL be treated as big-endian: byte offset 0 maps to bits [31:24] and offset 3 to bits [7:0].
REQ-019 mem_a SHALL equal {addr[31:2],2'b00} of the accepted request; mem_a, mem_wd and mem_we SHALL be registered outputs.
REQ-020 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WRITE and RESP; ready SHALL be 1 only in IDLE.
REQ-021 In IDLE with req=1, the request SHALL be captured (addr, we, size, sign_ext, wdata) and the FSM SHALL branch as follows:
- misaligned or reserved size: RESP
- load, or sub-word store: RD_ADDR
- word store: WRITE
REQ-022 Misaligned SHALL mean half with addr[0]=1, word with addr[1:0]!=0, or size=11; such requests SHALL make no memory access and SHALL return resp_err=1, rdata=0.
REQ-023 RD_ADDR SHALL hold mem_a stable for one cycle and then go to RD_DATA.
REQ-024 In RD_DATA, mem_rd SHALL be captured. For a load, the addressed lane SHALL be extracted, extended per sign_ext, placed in rdata, and the FSM SHALL go to RESP. For a sub-word store, the FSM SHALL go to WRITE.
REQ-025 For a sub-word store, the lanes of wdata[7:0] or wdata[15:0] SHALL be merged into the captured word at the addressed lane and all other bytes SHALL be preserved (read-modify-write).
REQ-026 In WRITE, mem_we SHALL be 1 for exactly one cycle with mem_wd equal to the full or merged word; the FSM SHALL then go to RESP.
REQ-027 In RESP, resp_valid SHALL be 1 for one cycle and the FSM SHALL return to IDLE; there is no back-pressure on the response.
REQ-028 Latency from the accept cycle to resp_valid SHALL be:
- load: 3 cycles
- word store: 2 cycles
- sub-word store: 4 cycles
- error: 1 cycle
REQ-029 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.
REQ-030 mem_we SHALL never be 1 outside WRITE, and at most one write SHALL occur per request.
REQ-031 req while ready=0 SHALL be ignored; the CPU holds req until it sees ready=1.
REQ-032 Address wrap SHALL be harmless: addr=32'hFFFF_FFFC word access SHALL use mem_a=32'hFFFF_FFFC with no carry logic.

Reset
REQ-033 Asserting rst_n=0 SHALL asynchronously force:
- state=IDLE, ready=1
- resp_valid=0, resp_err=0, rdata=0
- mem_a=0, mem_wd=0, mem_we=0
REQ-034 Reset during RD_* or WRITE SHALL abort the access with no write issued after reset assertion; a partial RMW SHALL never be completed.

Structure
REQ-035 A shared package mem_access_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-036 Lane extract, extend and merge logic SHALL live in one combinational sub-module, mem_lane_align, with inputs word, offset, size, sign_ext and wdata, and outputs load_val and merged_word.

Verification
REQ-037 Memory word 0x100=32'h8899_AABB; load byte, sign_ext=1, addr=0x101 -> rdata=32'hFFFF_FF99 three cycles after accept, resp_err=0.
REQ-038 Same word; load half, sign_ext=0, addr=0x102 -> rdata=32'h0000_AABB.
REQ-039 Store byte wdata=32'h0000_0011 at addr=0x102 -> one mem_we pulse with mem_wd=32'h8899_11BB at mem_a=0x100, resp_valid 4 cycles after accept.
REQ-040 Store word 32'hDEAD_BEEF at addr=0x200 -> mem_we pulse 1 cycle after accept, resp_valid after 2 cycles; a reload returns 32'hDEAD_BEEF.
REQ-041 Load word at addr=0x103, and size=11 -> resp_err=1, rdata=0, resp_valid 1 cycle after accept, no mem_we.
REQ-042 Assert rst_n=0 during RD_DATA of a byte store -> mem_we stays 0, memory word unchanged, ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, captured request.
// Purely declarative; no timing or flow control of its own.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Only the fields needed after the accept cycle are kept.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } mreq_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Combinational, zero latency; no flow control.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Offset 0 is the most significant byte.
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_val    = word;
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
        case (offset)
          2'd0:    merged_word[31:24] = wdata[7:0];
          2'd1:    merged_word[23:16] = wdata[7:0];
          2'd2:    merged_word[15:8]  = wdata[7:0];
          default: merged_word[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
        if (offset[1]) merged_word[15:0]  = wdata[15:0];
        else           merged_word[31:16] = wdata[15:0];
      end
      default: begin
        load_val    = word;
        merged_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit onto a big-endian word memory with read-modify-write for sub-word stores.
// Latency load 3, word store 2, sub-word store 4, error 1; ready only in IDLE, response never stalls.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_t      state_q, state_d;
  mreq_t       req_q;
  logic        accept;
  logic        err_in;
  logic        word_store;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  assign ready      = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = ready && req;
  assign err_in     = is_misaligned(size, addr[1:0]);
  assign word_store = we && (size == SZ_WORD);

  mem_lane_align u_align (
    .word        (mem_rd),
    .offset      (req_q.offset),
    .size        (req_q.size),
    .sign_ext    (req_q.sign_ext),
    .wdata       (req_q.wdata),
    .load_val    (load_val),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (err_in)          state_d = RESP;
          else if (word_store) state_d = WRITE;
          else                 state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = req_q.we ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_we is derived from the next state so it is high exactly while in WRITE;
  // reset clears it asynchronously, so an interrupted RMW never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      resp_err <= 1'b0;
      rdata    <= '0;
      mem_a    <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= (state_d == WRITE);
      if (accept) begin
        req_q.we       <= we;
        req_q.size     <= size;
        req_q.sign_ext <= sign_ext;
        req_q.offset   <= addr[1:0];
        req_q.wdata    <= wdata;
        resp_err       <= err_in;
        if (err_in)          rdata  <= '0;
        else                 mem_a  <= {addr[31:2], 2'b00};
        if (!err_in && word_store) mem_wd <= wdata;
      end
      if (state_q == RD_DATA) begin
        if (req_q.we) mem_wd <= merged_word;
        else          rdata  <= load_val;
      end
    end
  end

endmodule
